// File: rtl/data_ctrl_pkg.sv
// Shared types for the conv-tile data controller.
// State encoding and default register-file latency.
package data_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LDWTS,
        RFILL,
        MAC,
        FLUSH,
        WPOOL
    } state_e;

    localparam int RF_LAT_DEF = 2;

    // Width covering the fill burst plus the RF settle wait.
    function automatic int rc_width(input int ram_aw, input int rf_lat);
        return $clog2((1 << ram_aw) + rf_lat) + 1;
    endfunction

endpackage

// File: rtl/data_ctrl_cnt.sv
// Loadable up-counter with look-ahead value and terminal-count flag.
// The look-ahead lets the owner register outputs aligned with the count.
module data_ctrl_cnt
    import data_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] din,
    input  logic [W-1:0] last,
    output logic [W-1:0] nxt,
    output logic         tc
);

    logic [W-1:0] count;

    always_comb begin
        nxt = count;
        if (load)
            nxt = din;
        else if (inc)
            nxt = count + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else
            count <= nxt;
    end

    assign tc = (count == last);

endmodule

// File: rtl/data_ctrl_seq.sv
// Conv-tile sequencer: weight fetch, RF fill, MAC pass, flush, pool handshake.
// Define DATA_CTRL_PERF_EN to add stall_cycles / tile_count outputs.
module data_ctrl_seq
    import data_ctrl_pkg::*;
#(
    parameter int WTS_AW = 4,
    parameter int CH_W   = 8,
    parameter int RAM_AW = 5,
    parameter int RF_LAT = RF_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   cfg_num_ch,
    input  logic [WTS_AW:0]   cfg_wts_cnt,
    input  logic              pool_ready,
    input  logic              pool_done,
    output logic [WTS_AW-1:0] wts_bram_addr,
    output logic              enable_wts_rom,
    output logic              rf_enable,
    output logic [RAM_AW-1:0] ram_address,
    output logic              adder_enable,
    output logic              accumulator_reset,
    output logic              accumulator_enable,
    output logic [CH_W-1:0]   ch_idx,
    output logic              busy,
    output logic              tile_done
`ifdef DATA_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       tile_count
`endif
);

    localparam int RC_W = rc_width(RAM_AW, RF_LAT);
    localparam logic [RC_W-1:0] R_FILL = RC_W'(1 << RAM_AW);
    localparam logic [RC_W-1:0] R_LAST = RC_W'((1 << RAM_AW) + RF_LAT - 1);

    state_e state, state_n;

    logic              accept, finish, fill_n;
    logic              w_ld, w_inc, w_tc;
    logic              r_ld, r_inc, r_tc;
    logic              c_ld, c_inc, c_tc;
    logic [WTS_AW-1:0] w_nxt, wlast_d, wlast_q;
    logic [RC_W-1:0]   r_nxt;
    logic [CH_W-1:0]   c_nxt, clast_d, clast_q;

    assign accept = (state == IDLE) && start;
    assign finish = (state == WPOOL) && pool_done;
    assign fill_n = (state_n == RFILL) && (r_nxt < R_FILL);

    // Zero-sized tiles run as a single weight / single channel.
    always_comb begin
        wlast_d = '0;
        clast_d = '0;
        if (cfg_wts_cnt != '0)
            wlast_d = WTS_AW'(cfg_wts_cnt - 1'b1);
        if (cfg_num_ch != '0)
            clast_d = cfg_num_ch - 1'b1;
    end

    always_comb begin
        state_n = state;
        w_ld    = 1'b0;
        w_inc   = 1'b0;
        r_ld    = 1'b0;
        r_inc   = 1'b0;
        c_ld    = 1'b0;
        c_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = LDWTS;
                    w_ld    = 1'b1;
                    c_ld    = 1'b1;
                end
            end
            LDWTS: begin
                if (w_tc) begin
                    state_n = RFILL;
                    r_ld    = 1'b1;
                    w_ld    = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            RFILL: begin
                if (r_tc)
                    state_n = MAC;
                else
                    r_inc = 1'b1;
            end
            MAC: begin
                if (c_tc) begin
                    state_n = FLUSH;
                end else begin
                    state_n = RFILL;
                    r_ld    = 1'b1;
                    c_inc   = 1'b1;
                end
            end
            FLUSH: begin
                if (pool_ready)
                    state_n = WPOOL;
            end
            WPOOL: begin
                if (pool_done) begin
                    state_n = IDLE;
                    c_ld    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    data_ctrl_cnt #(.W(WTS_AW)) u_wcnt (
        .clock (clock),
        .reset (reset),
        .load  (w_ld),
        .inc   (w_inc),
        .din   ('0),
        .last  (wlast_q),
        .nxt   (w_nxt),
        .tc    (w_tc)
    );

    data_ctrl_cnt #(.W(RC_W)) u_rcnt (
        .clock (clock),
        .reset (reset),
        .load  (r_ld),
        .inc   (r_inc),
        .din   ('0),
        .last  (R_LAST),
        .nxt   (r_nxt),
        .tc    (r_tc)
    );

    data_ctrl_cnt #(.W(CH_W)) u_ccnt (
        .clock (clock),
        .reset (reset),
        .load  (c_ld),
        .inc   (c_inc),
        .din   ('0),
        .last  (clast_q),
        .nxt   (c_nxt),
        .tc    (c_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wlast_q <= '0;
            clast_q <= '0;
        end else if (accept) begin
            wlast_q <= wlast_d;
            clast_q <= clast_d;
        end
    end

    // Outputs are registered from next-state so they line up with state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            enable_wts_rom     <= 1'b0;
            wts_bram_addr      <= '0;
            rf_enable          <= 1'b0;
            ram_address        <= '0;
            adder_enable       <= 1'b0;
            accumulator_enable <= 1'b0;
            accumulator_reset  <= 1'b0;
            ch_idx             <= '0;
            busy               <= 1'b0;
            tile_done          <= 1'b0;
        end else begin
            state              <= state_n;
            enable_wts_rom     <= (state_n == LDWTS);
            wts_bram_addr      <= (state_n == LDWTS) ? w_nxt : '0;
            rf_enable          <= fill_n;
            ram_address        <= fill_n ? r_nxt[RAM_AW-1:0] : '0;
            adder_enable       <= (state_n == MAC);
            accumulator_enable <= (state_n == MAC);
            accumulator_reset  <= accept;
            ch_idx             <= c_nxt;
            busy               <= (state_n != IDLE);
            tile_done          <= finish;
        end
    end

`ifdef DATA_CTRL_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            tile_count   <= '0;
        end else begin
            if (accept)
                stall_cycles <= '0;
            else if (state == FLUSH || state == WPOOL)
                stall_cycles <= stall_cycles + 1'b1;
            if (finish)
                tile_count <= tile_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_ctrl_seq.sv
// Scoreboard bench for data_ctrl_seq.
// Expected strobes are queued at start and retired by a negedge monitor.
module tb_data_ctrl_seq;

    localparam int WTS_AW = 4;
    localparam int CH_W   = 8;
    localparam int RAM_AW = 2;
    localparam int RF_LAT = 2;
    localparam int PER_CH = (1 << RAM_AW) + RF_LAT + 1;

    logic              clock;
    logic              reset;
    logic              start;
    logic [CH_W-1:0]   cfg_num_ch;
    logic [WTS_AW:0]   cfg_wts_cnt;
    logic              pool_ready;
    logic              pool_done;
    logic [WTS_AW-1:0] wts_bram_addr;
    logic              enable_wts_rom;
    logic              rf_enable;
    logic [RAM_AW-1:0] ram_address;
    logic              adder_enable;
    logic              accumulator_reset;
    logic              accumulator_enable;
    logic [CH_W-1:0]   ch_idx;
    logic              busy;
    logic              tile_done;
`ifdef DATA_CTRL_PERF_EN
    logic [31:0]       stall_cycles;
    logic [15:0]       tile_count;
`endif

    data_ctrl_seq #(
        .WTS_AW (WTS_AW),
        .CH_W   (CH_W),
        .RAM_AW (RAM_AW),
        .RF_LAT (RF_LAT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .cfg_num_ch         (cfg_num_ch),
        .cfg_wts_cnt        (cfg_wts_cnt),
        .pool_ready         (pool_ready),
        .pool_done          (pool_done),
        .wts_bram_addr      (wts_bram_addr),
        .enable_wts_rom     (enable_wts_rom),
        .rf_enable          (rf_enable),
        .ram_address        (ram_address),
        .adder_enable       (adder_enable),
        .accumulator_reset  (accumulator_reset),
        .accumulator_enable (accumulator_enable),
        .ch_idx             (ch_idx),
        .busy               (busy),
        .tile_done          (tile_done)
`ifdef DATA_CTRL_PERF_EN
        ,
        .stall_cycles       (stall_cycles),
        .tile_count         (tile_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tiles_exp = 0;
    int q_wts[$];
    int q_ram[$];
    int q_mac[$];
    int q_ar[$];
    int q_done[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (enable_wts_rom) begin
                if (q_wts.size() == 0) chk("wts_extra", enable_wts_rom, 0);
                else chk("wts_addr", wts_bram_addr, q_wts.pop_front());
            end
            if (rf_enable) begin
                if (q_ram.size() == 0) chk("rf_extra", rf_enable, 0);
                else chk("ram_addr", ram_address, q_ram.pop_front());
            end
            if (adder_enable || accumulator_enable) begin
                chk("add_en", adder_enable, 1);
                chk("acc_en", accumulator_enable, 1);
                if (q_mac.size() == 0) chk("mac_extra", 1, 0);
                else chk("mac_ch", ch_idx, q_mac.pop_front());
            end
            if (accumulator_reset) begin
                if (q_ar.size() == 0) chk("acc_rst_extra", 1, 0);
                else chk("acc_rst_cyc", cyc, q_ar.pop_front());
            end
            if (tile_done) begin
                if (q_done.size() == 0) chk("done_extra", 1, 0);
                else chk("done_cyc", cyc, q_done.pop_front());
            end
        end
    end

    task automatic start_tile(input int wc, input int nc, input int extra,
                              output int c, output int f);
        int w, n;
        @(negedge clock);
        w = (wc == 0) ? 1 : wc;
        n = (nc == 0) ? 1 : nc;
        c = cyc;
        f = c + 1 + w + n * PER_CH;
        for (int i = 0; i < w; i++) q_wts.push_back(i);
        for (int ch = 0; ch < n; ch++) begin
            for (int a = 0; a < (1 << RAM_AW); a++) q_ram.push_back(a);
            q_mac.push_back(ch);
        end
        q_ar.push_back(c + 1);
        q_done.push_back(f + 2 + extra);
        tiles_exp++;
        cfg_wts_cnt = (WTS_AW + 1)'(wc);
        cfg_num_ch  = CH_W'(nc);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q_done.size() != 0 && n < 4000) begin
            @(negedge clock);
            n++;
        end
        chk("tile_timeout", q_done.size(), 0);
        q_done.delete();
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_ch", ch_idx, 0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    initial begin
        int c, f, n;
        reset = 1'b1;
        start = 1'b0;
        cfg_num_ch = '0;
        cfg_wts_cnt = '0;
        pool_ready = 1'b1;
        pool_done = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_wen", enable_wts_rom, 0);
        chk("rst_rf", rf_enable, 0);
        chk("rst_add", adder_enable, 0);
        chk("rst_done", tile_done, 0);
        chk("rst_ch", ch_idx, 0);
        reset = 1'b0;

        // basic tile plus zero-config and max-weight tiles
        start_tile(4, 2, 0, c, f);
        wait_done();
        start_tile(0, 0, 0, c, f);
        wait_done();
        start_tile(16, 3, 0, c, f);
        wait_done();

        // pool_ready held low for 10 cycles in FLUSH
        pool_ready = 1'b0;
        start_tile(3, 2, 10, c, f);
        wait_cyc(f);
        for (int i = 0; i < 10; i++) begin
            chk("stall_busy", busy, 1);
            chk("stall_add", adder_enable, 0);
            @(negedge clock);
        end
        pool_ready = 1'b1;
        wait_done();
`ifdef DATA_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles, 12);
        chk("tile_count", tile_count, tiles_exp);
`endif

        // start during MAC and cfg changes mid-tile are ignored
        start_tile(3, 3, 0, c, f);
        cfg_wts_cnt = 5'd9;
        cfg_num_ch = 8'd5;
        n = 0;
        while (!adder_enable && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("mac_seen", adder_enable, 1);
        cfg_wts_cnt = 5'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();

        // reset in RFILL aborts the tile
        start_tile(2, 2, 0, c, f);
        n = 0;
        while (!rf_enable && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("rf_seen", rf_enable, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        q_wts.delete();
        q_ram.delete();
        q_mac.delete();
        q_ar.delete();
        q_done.delete();
        tiles_exp = 0;
        chk("abort_busy", busy, 0);
        chk("abort_rf", rf_enable, 0);
        chk("abort_ram", ram_address, 0);
        chk("abort_ch", ch_idx, 0);
        chk("abort_done", tile_done, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("post_abort_busy", busy, 0);
        end
        start_tile(2, 1, 0, c, f);
        wait_done();
`ifdef DATA_CTRL_PERF_EN
        chk("tile_count_rst", tile_count, tiles_exp);
`endif

        // pool_done in FLUSH does not complete; second pool_done needed
        pool_ready = 1'b0;
        pool_done = 1'b0;
        start_tile(1, 1, 3, c, f);
        wait_cyc(f);
        pool_ready = 1'b1;
        pool_done = 1'b1;
        @(negedge clock);
        pool_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wpool_busy", busy, 1);
            chk("wpool_done", tile_done, 0);
            @(negedge clock);
        end
        pool_done = 1'b1;
        wait_done();

        chk("left_wts", q_wts.size(), 0);
        chk("left_ram", q_ram.size(), 0);
        chk("left_mac", q_mac.size(), 0);
        chk("left_ar", q_ar.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
